// File: rtl/uart_parity_engine_if.sv
// Parity engine bus: TX word/parity, RX bit stream, config and error status.
// master = UART control side, slave = uart_parity_engine.
interface uart_parity_engine_if #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_WIDTH = 8
);
  logic [2:0]           cfg_mode;
  logic [3:0]           cfg_width;
  logic                 Data_Valid;
  logic                 Busy;
  logic [MAX_WIDTH-1:0] DATA;
  logic                 parity;
  logic                 parity_valid;
  logic                 rx_start;
  logic                 rx_bit_valid;
  logic                 rx_bit;
  logic                 rx_done;
  logic                 par_err;
  logic                 par_err_sticky;
  logic [CNT_WIDTH-1:0] err_count;
  logic                 err_clear;

  modport master (
    output cfg_mode, cfg_width,
    output Data_Valid, Busy, DATA,
    output rx_start, rx_bit_valid, rx_bit,
    output err_clear,
    input  parity, parity_valid,
    input  rx_done, par_err,
    input  par_err_sticky, err_count
  );

  modport slave (
    input  cfg_mode, cfg_width,
    input  Data_Valid, Busy, DATA,
    input  rx_start, rx_bit_valid, rx_bit,
    input  err_clear,
    output parity, parity_valid,
    output rx_done, par_err,
    output par_err_sticky, err_count
  );
endinterface

// File: rtl/uart_parity_engine.sv
// UART parity unit: TX parity from a latched word, RX parity check on a
// bit-serial stream, error pulse/sticky/saturating count. Ports: CLK, RST, bus.
module uart_parity_engine #(
  parameter int MAX_WIDTH = 9,
  parameter int CNT_WIDTH = 8
) (
  input logic                 CLK,
  input logic                 RST,
  uart_parity_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M_NONE  = 3'd0,
    M_EVEN  = 3'd1,
    M_ODD   = 3'd2,
    M_MARK  = 3'd3,
    M_SPACE = 3'd4
  } mode_t;

  localparam logic [3:0] W_MIN = 4'd5;
  localparam logic [3:0] W_MAX = 4'(MAX_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [3:0] clamp_w(
    input logic [3:0] w
  );
    logic [3:0] r;
    r = w;
    if (w < W_MIN) r = W_MIN;
    else if (w > W_MAX) r = W_MAX;
    return r;
  endfunction

  // Reserved encodings 5-7 fold onto none.
  function automatic mode_t norm_mode(
    input logic [2:0] m
  );
    mode_t r;
    r = M_NONE;
    if (m <= 3'd4) r = mode_t'(m);
    return r;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] width_mask(
    input logic [3:0] w
  );
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      m[i] = (i < int'(w));
    end
    return m;
  endfunction

  function automatic logic exp_par(
    input mode_t m,
    input logic  x
  );
    logic r;
    r = 1'b0;
    unique case (m)
      M_EVEN:  r = x;
      M_ODD:   r = ~x;
      M_MARK:  r = 1'b1;
      M_SPACE: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------- TX path ----------------
  logic [MAX_WIDTH-1:0] tx_data_q, tx_data_d;
  mode_t                tx_mode_q, tx_mode_d;
  logic                 tx_lat_q, tx_lat_d;
  logic                 parity_q, parity_d;
  logic                 pv_q, pv_d;
  logic                 tx_take;

  assign tx_take = bus.Data_Valid && !bus.Busy;

  always_comb begin
    tx_data_d = tx_data_q;
    tx_mode_d = tx_mode_q;
    tx_lat_d  = tx_take;
    parity_d  = parity_q;
    pv_d      = tx_lat_q;
    if (tx_take) begin
      tx_data_d = bus.DATA & width_mask(clamp_w(bus.cfg_width));
      tx_mode_d = norm_mode(bus.cfg_mode);
    end
    // Parity is evaluated one edge after the latch, from latched copies.
    if (tx_lat_q) begin
      parity_d = exp_par(tx_mode_q, ^tx_data_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_data_q <= '0;
      tx_mode_q <= M_NONE;
      tx_lat_q  <= 1'b0;
      parity_q  <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      tx_mode_q <= tx_mode_d;
      tx_lat_q  <= tx_lat_d;
      parity_q  <= parity_d;
      pv_q      <= pv_d;
    end
  end

  assign bus.parity       = parity_q;
  assign bus.parity_valid = pv_q;

  // ---------------- RX path ----------------
  state_t     state_q, state_d;
  logic       acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  mode_t      rx_mode_q, rx_mode_d;
  logic [3:0] rx_w_q, rx_w_d;
  logic       mis_q, mis_d;
  logic       rx_restart;

  // A start in DONE is dropped; anywhere else it (re)opens a frame.
  assign rx_restart = bus.rx_start && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rx_mode_d = rx_mode_q;
    rx_w_d    = rx_w_q;
    mis_d     = mis_q;
    if (rx_restart) begin
      state_d   = S_DATA;
      acc_d     = 1'b0;
      cnt_d     = 4'd0;
      mis_d     = 1'b0;
      rx_mode_d = norm_mode(bus.cfg_mode);
      rx_w_d    = clamp_w(bus.cfg_width);
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_DATA: begin
          if (bus.rx_bit_valid) begin
            acc_d = acc_q ^ bus.rx_bit;
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == rx_w_q) begin
              state_d = (rx_mode_q == M_NONE) ? S_DONE : S_PAR;
            end
          end
        end
        S_PAR: begin
          if (bus.rx_bit_valid) begin
            mis_d   = bus.rx_bit != exp_par(rx_mode_q, acc_q);
            state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      acc_q     <= 1'b0;
      cnt_q     <= 4'd0;
      rx_mode_q <= M_NONE;
      rx_w_q    <= W_MIN;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rx_mode_q <= rx_mode_d;
      rx_w_q    <= rx_w_d;
      mis_q     <= mis_d;
    end
  end

  // ---------------- Status ----------------
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;

  always_comb begin
    done_d   = (state_q == S_DONE);
    perr_d   = (state_q == S_DONE) && mis_q;
    sticky_d = sticky_q;
    ecnt_d   = ecnt_q;
    // A same-cycle clear loses to the error: count restarts at one.
    if (perr_q) begin
      sticky_d = 1'b1;
      if (bus.err_clear) ecnt_d = CNT_ONE;
      else if (ecnt_q != CNT_MAX) ecnt_d = ecnt_q + CNT_ONE;
    end else if (bus.err_clear) begin
      sticky_d = 1'b0;
      ecnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      sticky_q <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      done_q   <= done_d;
      perr_q   <= perr_d;
      sticky_q <= sticky_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign bus.rx_done        = done_q;
  assign bus.par_err        = perr_q;
  assign bus.par_err_sticky = sticky_q;
  assign bus.err_count      = ecnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed bench for uart_parity_engine with TX/RX scoreboards.
// DUT built with MAX_WIDTH=9, CNT_WIDTH=2 so counter saturation is reachable.
module tb_uart_parity_engine;
  localparam int MW = 9;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_parity_engine_if #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) bus ();

  uart_parity_engine #(.MAX_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  bit txq[$];
  bit rxq[$];
  int n_pv = 0;
  int n_done = 0;
  bit live = 0;
  bit hold = 0;
  bit m_sticky = 0;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampw(input int w);
    if (w < 5) return 5;
    if (w > MW) return MW;
    return w;
  endfunction

  function automatic bit is_none(input int mode);
    return !(mode >= 1 && mode <= 4);
  endfunction

  function automatic bit mpar(input int mode, input int width,
                              input logic [MW-1:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < clampw(width); i++) ones += int'(d[i]);
    case (mode)
      1: return bit'(ones % 2);
      2: return !bit'(ones % 2);
      3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    bit e;
    @(posedge CLK);
    #1;
    if (bus.parity_valid === 1'b1) begin
      n_pv++;
      chk("tx_pulse_expected", txq.size() != 0, 1);
      if (txq.size() != 0) begin
        e = txq.pop_front();
        hold = e;
        chk("tx_parity", bus.parity, e);
      end
    end
    if (live) chk("tx_parity_hold", bus.parity, hold);
    if (bus.rx_done === 1'b1) begin
      n_done++;
      chk("rx_done_expected", rxq.size() != 0, 1);
      if (rxq.size() != 0) begin
        e = rxq.pop_front();
        chk("rx_par_err", bus.par_err, e);
      end
    end
    if (bus.par_err === 1'b1) chk("par_err_with_done", bus.rx_done, 1);
  endtask

  task automatic tx(input int mode, input int width,
                    input logic [MW-1:0] d, input bit busy);
    bus.cfg_mode   = 3'(mode);
    bus.cfg_width  = 4'(width);
    bus.DATA       = d;
    bus.Data_Valid = 1'b1;
    bus.Busy       = busy;
    if (!busy) txq.push_back(mpar(mode, width, d));
    step();
  endtask

  task automatic rx_wait(input bit clr, input string tag);
    int base;
    int k;
    base = n_done;
    k = 0;
    while (n_done == base && k < 6) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, n_done, base + 1);
    chk({tag, "_latency"}, k, 1);
    bus.err_clear = clr;
    step();
    bus.err_clear = 1'b0;
    chk({tag, "_sticky"}, bus.par_err_sticky, m_sticky);
    chk({tag, "_count"}, bus.err_count, m_cnt);
  endtask

  task automatic rx_frame(input int mode, input int width,
                          input logic [MW-1:0] d, input bit pbit,
                          input bit clr, input string tag);
    int w;
    bit err;
    w = clampw(width);
    err = !is_none(mode) && (pbit != mpar(mode, width, d));
    rxq.push_back(err);
    if (err) begin
      m_sticky = 1;
      m_cnt = clr ? 1 : (m_cnt == CMAX ? CMAX : m_cnt + 1);
    end else if (clr) begin
      m_sticky = 0;
      m_cnt = 0;
    end
    bus.cfg_mode  = 3'(mode);
    bus.cfg_width = 4'(width);
    bus.rx_start  = 1'b1;
    step();
    bus.rx_start  = 1'b0;
    bus.cfg_mode  = (mode == 3) ? 3'd4 : 3'd3;
    bus.cfg_width = (w == 5) ? 4'd9 : 4'd5;
    for (int i = 0; i < w; i++) begin
      bus.rx_bit_valid = 1'b1;
      bus.rx_bit = d[i];
      step();
    end
    if (!is_none(mode)) begin
      bus.rx_bit = pbit;
      step();
    end
    bus.rx_bit_valid = 1'b0;
    rx_wait(clr, tag);
  endtask

  initial begin
    int b;
    RST = 1'b1;
    bus.cfg_mode = 3'd0;
    bus.cfg_width = 4'd8;
    bus.Data_Valid = 1'b0;
    bus.Busy = 1'b0;
    bus.DATA = '0;
    bus.rx_start = 1'b0;
    bus.rx_bit_valid = 1'b0;
    bus.rx_bit = 1'b0;
    bus.err_clear = 1'b0;
    step();
    step();
    RST = 1'b0;
    chk("rst_parity", bus.parity, 0);
    chk("rst_parity_valid", bus.parity_valid, 0);
    chk("rst_rx_done", bus.rx_done, 0);
    chk("rst_par_err", bus.par_err, 0);
    chk("rst_sticky", bus.par_err_sticky, 0);
    chk("rst_count", bus.err_count, 0);
    live = 1;
    hold = 0;

    // TX: back-to-back latches, width clamping and all modes.
    b = n_pv;
    tx(1, 8, 9'h096, 0);
    tx(2, 8, 9'h096, 0);
    tx(1, 8, 9'h180, 0);
    tx(1, 7, 9'h180, 0);
    tx(1, 2, 9'h1F0, 0);
    tx(1, 15, 9'h100, 0);
    tx(2, 9, 9'h1FF, 0);
    tx(4, 8, 9'h0FF, 0);
    tx(0, 8, 9'h001, 0);
    tx(6, 8, 9'h001, 0);
    tx(3, 5, 9'h000, 0);
    bus.Data_Valid = 1'b0;
    step();
    step();
    chk("tx_burst_pulses", n_pv - b, 11);
    chk("tx_burst_last", bus.parity, 1);

    // TX: busy blocks the latch.
    b = n_pv;
    tx(1, 8, 9'h001, 1);
    tx(2, 8, 9'h000, 1);
    bus.Data_Valid = 1'b0;
    bus.Busy = 1'b0;
    step();
    step();
    chk("tx_busy_no_pulse", n_pv - b, 0);
    chk("tx_busy_parity", bus.parity, 1);

    // RX frames.
    rx_frame(2, 8, 9'h001, 1'b0, 0, "rx_odd_ok");
    rx_frame(2, 8, 9'h001, 1'b1, 0, "rx_odd_err");
    rx_frame(3, 5, 9'h015, 1'b0, 0, "rx_mark_err");
    rx_frame(4, 5, 9'h015, 1'b0, 0, "rx_space_ok");
    rx_frame(0, 5, 9'h01B, 1'b0, 0, "rx_none");
    rx_frame(7, 3, 9'h01B, 1'b0, 0, "rx_mode7_none");
    rx_frame(1, 12, 9'h1C3, 1'b1, 0, "rx_even_w9_ok");

    // Abort after three data bits, then a full frame.
    b = n_done;
    bus.cfg_mode = 3'd1;
    bus.cfg_width = 4'd8;
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rx_bit_valid = 1'b1;
      bus.rx_bit = 1'b1;
      step();
    end
    bus.rx_bit_valid = 1'b0;
    rx_frame(2, 8, 9'h0A5, mpar(2, 8, 9'h0A5), 0, "rx_after_abort");
    chk("abort_one_done", n_done - b, 1);

    // Reset while in PAR.
    tx(3, 8, 9'h000, 0);
    bus.Data_Valid = 1'b0;
    step();
    step();
    bus.cfg_mode = 3'd1;
    bus.cfg_width = 4'd5;
    bus.rx_start = 1'b1;
    step();
    bus.rx_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rx_bit_valid = 1'b1;
      bus.rx_bit = 1'b1;
      step();
    end
    b = n_done;
    RST = 1'b1;
    bus.rx_bit = 1'b0;
    hold = 0;
    step();
    RST = 1'b0;
    m_sticky = 0;
    m_cnt = 0;
    chk("rstpar_parity", bus.parity, 0);
    chk("rstpar_rx_done", bus.rx_done, 0);
    chk("rstpar_par_err", bus.par_err, 0);
    chk("rstpar_sticky", bus.par_err_sticky, 0);
    chk("rstpar_count", bus.err_count, 0);
    for (int i = 0; i < 7; i++) step();
    bus.rx_bit_valid = 1'b0;
    step();
    step();
    chk("rstpar_no_done", n_done - b, 0);

    // Counter saturation and clear-vs-error priority.
    for (int i = 0; i < 5; i++) rx_frame(1, 5, 9'h003, 1'b1, 0, "rx_sat");
    chk("sat_count", bus.err_count, CMAX);
    rx_frame(1, 5, 9'h003, 1'b1, 1, "rx_clr_err");
    rx_frame(1, 5, 9'h003, 1'b0, 1, "rx_clr_only");

    chk("txq_drained", txq.size(), 0);
    chk("rxq_drained", rxq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
